pc_unit: RTL and testbench

- Parametrised successor to the current program counter, sitting in the IF stage. Holds the fetch PC and selects the next PC from four sources, in priority order: trap vector, immediate redirect, return-address-stack (RAS) pop, sequential +4.
- Every candidate target is bounds- and alignment-checked before it is loaded. A bad target raises a sticky halt with a cause code, and the PC is never loaded with it.
- Adds a small circular return-address stack so that call/return targets come from inside the unit.

---
 rtl/pc_unit.sv | 131 +++++++++++++
 tb/tb_pc_unit.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/pc_unit.sv
// Fetch program counter for the IF stage. Next PC comes from the trap vector, an immediate
// redirect, the return-address stack or PC+4. Any bad target raises a sticky halt instead.
module pc_unit #(
  parameter int unsigned     XLEN       = 32,
  parameter logic [XLEN-1:0] IMEM_BASE  = 32'h0100_0000,
  parameter logic [XLEN-1:0] IMEM_SIZE  = 32'h0000_0800,
  parameter logic [XLEN-1:0] RESET_ADDR = IMEM_BASE,
  parameter int unsigned     RAS_DEPTH  = 4
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            we,
  input  logic            imm,
  input  logic [XLEN-1:0] imm_addr,
  input  logic            trap,
  input  logic [XLEN-1:0] trap_vec,
  input  logic            push,
  input  logic            pop,
  output logic [XLEN-1:0] instr_addr,
  output logic            halt,
  output logic [1:0]      halt_cause,
  output logic            ras_empty,
  output logic            ras_full
);

  localparam int unsigned     PW        = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
  localparam logic [XLEN-1:0] LAST_PC   = IMEM_BASE + IMEM_SIZE - XLEN'(4);
  localparam logic [1:0]      CAUSE_OOB = 2'd1;
  localparam logic [1:0]      CAUSE_MIS = 2'd2;
  localparam logic [1:0]      CAUSE_UNF = 2'd3;

  logic [XLEN-3:0] pc_q, pc_d;
  logic            halt_q, halt_d;
  logic [1:0]      cause_q, cause_d;
  logic [PW-1:0]   sp_q, sp_d;
  logic [PW:0]     cnt_q, cnt_d;
  logic [XLEN-1:0] ras_q [RAS_DEPTH];

  logic            ras_we;
  logic [PW-1:0]   ras_waddr;
  logic [XLEN-1:0] ras_wdata;

  logic [XLEN-1:0] pc_cur, pc_inc, ras_top, target;
  logic [PW-1:0]   top_idx;
  logic            pop_sel, underflow, misaligned, out_of_bounds, full;

  assign pc_cur  = {pc_q, 2'b00};
  assign pc_inc  = pc_cur + XLEN'(4);
  assign top_idx = sp_q - 1'b1;
  assign ras_top = ras_q[top_idx];
  assign full    = (cnt_q == (PW+1)'(RAS_DEPTH));

  // A pop only counts when neither redirect outranks it.
  assign pop_sel = pop && !trap && !imm;

  always_comb begin
    target = pc_inc;
    if (trap)         target = trap_vec;
    else if (imm)     target = imm_addr;
    else if (pop_sel) target = ras_top;
  end

  assign underflow     = pop_sel && (cnt_q == '0);
  assign misaligned    = (target[1:0] != 2'b00);
  assign out_of_bounds = (target < IMEM_BASE) || (target > LAST_PC);

  always_comb begin
    pc_d      = pc_q;
    halt_d    = halt_q;
    cause_d   = cause_q;
    sp_d      = sp_q;
    cnt_d     = cnt_q;
    ras_we    = 1'b0;
    ras_waddr = sp_q;
    ras_wdata = pc_inc;
    if (we && !halt_q) begin
      if (underflow) begin
        halt_d  = 1'b1;
        cause_d = CAUSE_UNF;
      end else if (misaligned) begin
        halt_d  = 1'b1;
        cause_d = CAUSE_MIS;
      end else if (out_of_bounds) begin
        halt_d  = 1'b1;
        cause_d = CAUSE_OOB;
      end else begin
        pc_d = target[XLEN-1:2];
        // Push+pop swaps the top entry in place; a lone push overwrites the oldest when full.
        if (push && pop_sel) begin
          ras_we    = 1'b1;
          ras_waddr = top_idx;
        end else if (push) begin
          ras_we = 1'b1;
          sp_d   = sp_q + 1'b1;
          if (!full) cnt_d = cnt_q + 1'b1;
        end else if (pop_sel) begin
          sp_d  = sp_q - 1'b1;
          cnt_d = cnt_q - 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      pc_q    <= RESET_ADDR[XLEN-1:2];
      halt_q  <= 1'b0;
      cause_q <= 2'd0;
      sp_q    <= '0;
      cnt_q   <= '0;
    end else begin
      pc_q    <= pc_d;
      halt_q  <= halt_d;
      cause_q <= cause_d;
      sp_q    <= sp_d;
      cnt_q   <= cnt_d;
    end
  end

  // Stack entries are plain storage; their contents after reset are irrelevant.
  always_ff @(posedge clk) begin
    if (ras_we) ras_q[ras_waddr] <= ras_wdata;
  end

  assign instr_addr = pc_cur;
  assign halt       = halt_q;
  assign halt_cause = cause_q;
  assign ras_empty  = (cnt_q == '0);
  assign ras_full   = full;

endmodule

// File: tb/tb_pc_unit.sv
// Bench for pc_unit: directed vector table from the test plan, then randomized traffic
// compared against a queue-based reference model of the fetch PC and return stack.
module tb_pc_unit;

  localparam logic [31:0] B    = 32'h0100_0000;
  localparam logic [31:0] SIZE = 32'h0000_0800;
  localparam int          D    = 4;

  logic        clk = 1'b0;
  logic        rstn, we, imm, trap, push, pop;
  logic [31:0] imm_addr, trap_vec, instr_addr;
  logic        halt, ras_empty, ras_full;
  logic [1:0]  halt_cause;

  int checks = 0;
  int errors = 0;

  pc_unit dut (
    .clk(clk), .rstn(rstn), .we(we), .imm(imm), .imm_addr(imm_addr),
    .trap(trap), .trap_vec(trap_vec), .push(push), .pop(pop),
    .instr_addr(instr_addr), .halt(halt), .halt_cause(halt_cause),
    .ras_empty(ras_empty), .ras_full(ras_full)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          rst;
    bit          we, imm, trap, push, pop;
    logic [31:0] ia, tv;
    logic [31:0] ea;
    bit          eh;
    logic [1:0]  ec;
    bit          ee, ef;
  } vec_t;

  vec_t vq[$];

  task automatic add(input bit r, input bit w, input bit i, input bit t, input bit pu,
                     input bit po, input logic [31:0] ia, input logic [31:0] tv,
                     input logic [31:0] ea, input bit eh, input logic [1:0] ec,
                     input bit ee, input bit ef);
    vec_t v;
    v.rst = r; v.we = w; v.imm = i; v.trap = t; v.push = pu; v.pop = po;
    v.ia = ia; v.tv = tv; v.ea = ea; v.eh = eh; v.ec = ec; v.ee = ee; v.ef = ef;
    vq.push_back(v);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    we = 0; imm = 0; trap = 0; push = 0; pop = 0; imm_addr = 0; trap_vec = 0;
  endtask

  // Reference model: PC as a plain address, RAS as a bounded queue (newest at the back).
  logic [31:0] m_pc;
  bit          m_halt;
  logic [1:0]  m_cause;
  logic [31:0] m_ras[$];

  task automatic model_reset();
    m_pc = B; m_halt = 0; m_cause = 0; m_ras.delete();
  endtask

  task automatic model_step();
    bit          popsel;
    logic [31:0] tgt, ret;
    if (!we || m_halt) return;
    popsel = pop && !trap && !imm;
    if (popsel && m_ras.size() == 0) begin
      m_halt = 1; m_cause = 3; return;
    end
    ret = m_pc + 4;
    if (trap)        tgt = trap_vec;
    else if (imm)    tgt = imm_addr;
    else if (popsel) tgt = m_ras[$];
    else             tgt = ret;
    if (tgt % 4 != 0) begin
      m_halt = 1; m_cause = 2;
    end else if (tgt < B || tgt > B + SIZE - 4) begin
      m_halt = 1; m_cause = 1;
    end else begin
      if (push && popsel) m_ras[m_ras.size()-1] = ret;
      else if (popsel) void'(m_ras.pop_back());
      else if (push) begin
        m_ras.push_back(ret);
        if (m_ras.size() > D) void'(m_ras.pop_front());
      end
      m_pc = tgt;
    end
  endtask

  task automatic model_compare(input string tag);
    chk({tag, " addr"},  instr_addr, m_pc);
    chk({tag, " halt"},  halt, m_halt);
    chk({tag, " cause"}, halt_cause, m_cause);
    chk({tag, " empty"}, ras_empty, m_ras.size() == 0);
    chk({tag, " full"},  ras_full, m_ras.size() == D);
  endtask

  function automatic logic [31:0] rnd_addr();
    int unsigned r;
    r = $urandom_range(0, 15);
    case (r)
      0:       return B + 4 * $urandom_range(0, 511) + $urandom_range(1, 3);
      1:       return B - 4 * $urandom_range(1, 4);
      2:       return B + SIZE + 4 * $urandom_range(0, 3);
      3, 4:    return B + SIZE - 4 * $urandom_range(1, 2);
      default: return B + 4 * $urandom_range(0, 511);
    endcase
  endfunction

  initial begin
    vec_t v;
    int   hcnt;
    idle_inputs();
    rstn = 0;

    // Directed vectors from the test plan; rst rows pulse reset mid-cycle and check during it.
    add(1,0,0,0,0,0, 0,0, B,0,0,1,0);
    add(0,1,0,0,0,0, 0,0, B+32'h04,0,0,1,0);
    add(0,1,0,0,0,0, 0,0, B+32'h08,0,0,1,0);
    add(0,1,0,0,0,0, 0,0, B+32'h0C,0,0,1,0);
    add(0,1,0,0,0,0, 0,0, B+32'h10,0,0,1,0);
    add(0,0,1,0,0,0, B+32'h100,0, B+32'h10,0,0,1,0);
    add(0,1,1,0,0,0, B+32'h100,0, B+32'h100,0,0,1,0);
    add(0,1,1,1,0,0, B+32'h100,B+32'h40, B+32'h40,0,0,1,0);
    add(0,1,1,0,0,0, B+32'h20,0, B+32'h20,0,0,1,0);
    add(0,1,1,0,1,0, B+32'h200,0, B+32'h200,0,0,0,0);
    add(0,1,0,0,0,1, 0,0, B+32'h24,0,0,1,0);
    add(0,1,0,0,0,1, 0,0, B+32'h24,1,3,1,0);
    add(0,1,1,0,1,0, B+32'h100,0, B+32'h24,1,3,1,0);
    add(0,0,1,0,1,1, B+32'h100,0, B+32'h24,1,3,1,0);
    add(1,0,0,0,0,0, 0,0, B,0,0,1,0);
    add(0,1,0,0,1,0, 0,0, B+32'h04,0,0,0,0);
    add(0,1,0,0,1,0, 0,0, B+32'h08,0,0,0,0);
    add(0,1,0,0,1,0, 0,0, B+32'h0C,0,0,0,0);
    add(0,1,0,0,1,0, 0,0, B+32'h10,0,0,0,1);
    add(0,1,0,0,1,0, 0,0, B+32'h14,0,0,0,1);
    add(0,1,0,0,0,1, 0,0, B+32'h14,0,0,0,0);
    add(0,1,0,0,0,1, 0,0, B+32'h10,0,0,0,0);
    add(0,1,0,0,0,1, 0,0, B+32'h0C,0,0,0,0);
    add(0,1,0,0,0,1, 0,0, B+32'h08,0,0,1,0);
    add(0,1,1,0,0,0, B+32'h102,0, B+32'h08,1,2,1,0);
    add(1,0,0,0,0,0, 0,0, B,0,0,1,0);
    add(0,1,1,0,0,0, B+32'h800,0, B,1,1,1,0);
    add(1,0,0,0,0,0, 0,0, B,0,0,1,0);
    add(0,1,1,0,0,0, 32'h00FF_FFFC,0, B,1,1,1,0);
    add(1,0,0,0,0,0, 0,0, B,0,0,1,0);
    add(0,1,1,0,0,0, B+32'h7FC,0, B+32'h7FC,0,0,1,0);
    add(0,1,0,0,0,0, 0,0, B+32'h7FC,1,1,1,0);
    add(1,0,0,0,0,0, 0,0, B,0,0,1,0);
    add(0,1,0,0,1,0, 0,0, B+32'h04,0,0,0,0);
    add(0,1,1,0,0,0, B+32'h300,0, B+32'h300,0,0,0,0);
    add(0,1,0,0,1,1, 0,0, B+32'h04,0,0,0,0);
    add(0,1,0,0,0,1, 0,0, B+32'h304,0,0,1,0);
    add(0,1,1,0,0,1, B+32'h400,0, B+32'h400,0,0,1,0);
    add(0,1,0,1,0,0, 0,B+32'h401, B+32'h400,1,2,1,0);
    add(0,1,1,0,0,0, 32'h0,0, B+32'h400,1,2,1,0);

    @(posedge clk);
    #1;
    for (int k = 0; k < vq.size(); k++) begin
      v = vq[k];
      if (v.rst) begin
        idle_inputs();
        rstn = 0;
        #1;
      end else begin
        rstn = 1;
        we = v.we; imm = v.imm; trap = v.trap; push = v.push; pop = v.pop;
        imm_addr = v.ia; trap_vec = v.tv;
        @(posedge clk);
        #1;
      end
      chk($sformatf("v%0d addr", k),  instr_addr, v.ea);
      chk($sformatf("v%0d halt", k),  halt, v.eh);
      chk($sformatf("v%0d cause", k), halt_cause, v.ec);
      chk($sformatf("v%0d empty", k), ras_empty, v.ee);
      chk($sformatf("v%0d full", k),  ras_full, v.ef);
      if (v.rst) begin
        #2;
        rstn = 1;
      end
    end

    // Randomized traffic against the reference model, resetting a few cycles after each halt.
    idle_inputs();
    rstn = 0;
    model_reset();
    #1;
    model_compare("rnd reset");
    #2;
    rstn = 1;
    hcnt = 0;
    for (int n = 0; n < 3000; n++) begin
      we       = ($urandom_range(0, 3) != 0);
      trap     = ($urandom_range(0, 15) == 0);
      imm      = ($urandom_range(0, 3) == 0);
      push     = ($urandom_range(0, 2) == 0);
      pop      = ($urandom_range(0, 3) == 0);
      imm_addr = rnd_addr();
      trap_vec = rnd_addr();
      model_step();
      @(posedge clk);
      #1;
      model_compare($sformatf("rnd%0d", n));
      if (m_halt) hcnt++;
      if (hcnt > 4) begin
        idle_inputs();
        rstn = 0;
        model_reset();
        #1;
        model_compare($sformatf("rnd%0d rst", n));
        #2;
        rstn = 1;
        hcnt = 0;
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
